// File: rtl/dec_pkg.sv
// dec_pkg: shared mode encodings and the one-hot helper used by the
// dec_nx_scan decoder family.
package dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers cast their result down
    // to 2^N bits.
    localparam int N_MAX = 10;

    // One-hot image of sel: bit sel set, every other bit clear.
    function automatic logic [(1<<N_MAX)-1:0] onehot(input logic [N_MAX-1:0] sel);
        logic [(1<<N_MAX)-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_n.sv
// dec_n: combinational N-to-2^N one-hot decoder with enable.
// A low enable forces all outputs to zero.
import dec_pkg::*;

module dec_n #(
    parameter int N = 3
) (
    input  logic             en,
    input  logic [N-1:0]     sel,
    output logic [(1<<N)-1:0] y
);

    localparam int W = 1 << N;

    // Decode sel to a single set bit, or all zeros when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y = W'(onehot(N_MAX'(sel)));
        end
    end

endmodule

// File: rtl/dec_nx_scan.sv
// dec_nx_scan: registered N-to-2^N one-hot decoder with a DIRECT mode
// (decode `in`) and a SCAN mode (walk every output, DWELL cycles each).
// Optional feature macro: DEC_SKIP_MASK_EN adds a `skip` mask; a scan
// advance then jumps to the next unmasked index, and a fully masked scan
// parks with out=0 and idx/dwell frozen.
import dec_pkg::*;

module dec_nx_scan #(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      in,
`ifdef DEC_SKIP_MASK_EN
    input  logic [(1<<N)-1:0] skip,
`endif
    output logic [(1<<N)-1:0] out,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W  = 1 << N;
    // Dwell counter is at least one bit so DWELL=1 still has a register
    // (it simply never leaves zero).
    localparam int CW = (DWELL <= 2) ? 1 : $clog2(DWELL);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [W-1:0]  out_q, out_d;
    logic          wrap_q, wrap_d;

    logic [N-1:0]  adv_idx;
    logic          adv_wrap;
    logic          scan_blocked;
    logic          dec_en;

`ifdef DEC_SKIP_MASK_EN
    // Next unmasked index above idx, circularly. Walking offsets from
    // largest to smallest lets the nearest candidate win. Offset W lands
    // back on idx itself, covering the case where only idx is unmasked.
    always_comb begin
        logic [N-1:0] cand;
        cand    = idx_q;
        adv_idx = idx_q;
        for (int k = W; k >= 1; k--) begin
            cand = idx_q + N'(k);
            if (!skip[cand]) begin
                adv_idx = cand;
            end
        end
        // The search crossed index 0 exactly when it did not move upward.
        adv_wrap     = (adv_idx <= idx_q);
        scan_blocked = &skip;
    end
`else
    // Plain increment; the N-bit add wraps to 0 by itself.
    always_comb begin
        adv_idx      = idx_q + N'(1);
        adv_wrap     = (idx_q == {N{1'b1}});
        scan_blocked = 1'b0;
    end
`endif

    // Next-state selection: idle hold, DIRECT/load capture, or scan advance.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        dec_en  = 1'b0;
        if (E) begin
            dec_en = 1'b1;
            if (mode == MODE_DIRECT || load) begin
                // DIRECT ignores load; both capture `in` and restart dwell.
                idx_d   = in;
                dwell_d = '0;
            end else if (scan_blocked) begin
                dec_en = 1'b0;
            end else if (dwell_q == DWELL_LAST) begin
                idx_d   = adv_idx;
                dwell_d = '0;
                wrap_d  = adv_wrap;
            end else begin
                dwell_d = dwell_q + CW'(1);
            end
        end
    end

    dec_n #(.N(N)) u_dec (
        .en  (dec_en),
        .sel (idx_d),
        .y   (out_d)
    );

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            dwell_q <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
